down_count_timer: RTL and testbench

- Loadable synchronous down-counter/timer: the counting-down counterpart to the team's up counter.
- Software or an upstream FSM loads a start value. The block decrements on each enabled cycle and flags terminal count.
- It then either stops or reloads, for one-shot delays or periodic ticks.
- Used as a delay/interval generator beside the up counters in the same clock domain.

---
 rtl/down_count_timer.sv | 105 ++++++++++
 tb/tb_down_count_timer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/down_count_timer.sv
// Loadable down-counter/timer with terminal-count pulse, one-shot or periodic reload.
// Used as a delay/interval generator in the same clock domain as the up counters.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | not counting; q holds its last value, en ignored
// RUN    | decrementing once per en cycle; busy=1
// DONE   | one-shot finished; q=0, done=1, waits for load or reset
module down_count_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  input  logic             stop,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = done_q;
    tc_d     = 1'b0;

    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      done_d   = 1'b0;
      state_d  = (load_val != CNT_ZERO) ? S_RUN : S_IDLE;
    end else begin
      case (state_q)
        S_RUN: begin
          if (stop) begin
            state_d = S_IDLE;
          end else if (en) begin
            if (count_q > CNT_ONE) begin
              count_d = count_q - CNT_ONE;
            end else if (count_q == CNT_ONE) begin
              // terminal edge: auto_reload is only looked at here
              tc_d = 1'b1;
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                count_d = CNT_ZERO;
                state_d = S_DONE;
                done_d  = 1'b1;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end

    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign q    = count_q;
  assign tc   = tc_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_down_count_timer.sv
// Bench for down_count_timer: directed scenarios plus random stimulus,
// all checked against a cycle-level behavioural model of the timer.
module tb_down_count_timer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         en = 1'b0;
  logic         auto_reload = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] q;
  logic         tc, busy, done;

  down_count_timer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
    .auto_reload(auto_reload), .stop(stop), .q(q), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model: mode 0=idle 1=counting 2=finished
  int m_mode, m_q, m_rl, m_tc, m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_q = 0; m_rl = 0; m_tc = 0; m_done = 0;
  endtask

  task automatic model_edge();
    m_tc = 0;
    if (load) begin
      m_q = int'(load_val); m_rl = int'(load_val); m_done = 0;
      m_mode = (load_val != 0) ? 1 : 0;
    end else if (m_mode == 1) begin
      if (stop) m_mode = 0;
      else if (en) begin
        if (m_q > 1) m_q = m_q - 1;
        else begin
          m_tc = 1;
          if (auto_reload) m_q = m_rl;
          else begin m_q = 0; m_mode = 2; m_done = 1; end
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".q"}, q, m_q);
    chk({tag, ".tc"}, tc, m_tc);
    chk({tag, ".busy"}, busy, (m_mode == 1) ? 1 : 0);
    chk({tag, ".done"}, done, m_done);
  endtask

  task automatic drive(input logic l, input logic [W-1:0] lv, input logic e,
                       input logic s, input logic ar);
    load = l; load_val = lv; en = e; stop = s; auto_reload = ar;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  int tcs, n;
  logic [3:0] gap_pat;
  logic [7:0] en_pat;

  initial begin
    model_reset();
    #12;
    chk("reset.q", q, 0);
    chk("reset.busy", busy, 0);
    chk("reset.tc", tc, 0);
    chk("reset.done", done, 0);
    @(negedge clk); rst = 1'b1;

    // reset while running, asserted mid-cycle
    drive(1, 4'd9, 0, 0, 0); step("rr.load");
    drive(0, 4'd0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("rr.run");
    chk("rr.q_before", q, 6);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("rr.async_q", q, 0);
    chk("rr.async_busy", busy, 0);
    chk("rr.async_tc", tc, 0);
    chk("rr.async_done", done, 0);
    @(negedge clk); rst = 1'b1;

    // one-shot of 4
    drive(1, 4'd4, 1, 0, 0); step("os.load");
    chk("os.q0", q, 4);
    drive(0, 4'd0, 1, 0, 0);
    for (int i = 3; i >= 0; i--) begin
      step("os.run");
      chk("os.qseq", q, i);
      chk("os.tcseq", tc, (i == 0) ? 1 : 0);
    end
    chk("os.done", done, 1);
    chk("os.busy", busy, 0);
    for (int i = 0; i < 3; i++) step("os.after");
    chk("os.after_tc", tc, 0);

    // periodic with enable gaps
    drive(1, 4'd3, 1, 0, 1); step("pg.load");
    en_pat = 8'b1110_1101; // applied LSB first: 1,0,1,1,0,1,1,1
    tcs = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 4'd0, en_pat[i], 0, 1);
      step("pg.run");
      tcs += tc;
      chk("pg.busy", busy, 1);
    end
    chk("pg.tc_count", tcs, 2);
    chk("pg.q_end", q, 3);

    // simultaneous events
    drive(1, 4'd5, 0, 1, 0); step("sim.loadstop");
    chk("sim.q5", q, 5);
    chk("sim.busy", busy, 1);
    drive(0, 4'd0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("sim.cnt");
    drive(0, 4'd0, 1, 1, 0); step("sim.stop");
    chk("sim.stop_q", q, 2);
    chk("sim.stop_busy", busy, 0);
    drive(0, 4'd0, 1, 0, 0); step("sim.idle_en");
    chk("sim.idle_hold", q, 2);
    drive(1, 4'd7, 1, 0, 0); step("sim.load_en");
    chk("sim.load_noddec", q, 7);

    // boundaries
    drive(1, 4'd0, 1, 0, 1); step("bz.load");
    drive(0, 4'd0, 1, 0, 1);
    tcs = 0;
    for (int i = 0; i < 4; i++) begin step("bz.run"); tcs += tc; end
    chk("bz.q", q, 0);
    chk("bz.no_tc", tcs, 0);

    drive(1, 4'd15, 1, 0, 0); step("b15.load");
    drive(0, 4'd0, 1, 0, 0);
    n = 0;
    for (int i = 0; i < 40 && tc !== 1'b1; i++) begin step("b15.run"); n++; end
    chk("b15.cycles_to_tc", n, 15);

    drive(1, 4'd1, 1, 0, 1); step("b1.load");
    drive(0, 4'd0, 1, 0, 1);
    tcs = 0;
    for (int i = 0; i < 4; i++) begin step("b1.run"); tcs += tc; chk("b1.q", q, 1); end
    chk("b1.tc_count", tcs, 4);

    // auto_reload changed between terminal edges
    drive(1, 4'd2, 1, 0, 1); step("ms.load");
    drive(0, 4'd0, 1, 0, 1);
    step("ms.r1"); step("ms.r2");
    chk("ms.reload_q", q, 2);
    chk("ms.reload_tc", tc, 1);
    drive(0, 4'd0, 1, 0, 0);
    step("ms.r3"); step("ms.r4");
    chk("ms.done_q", q, 0);
    chk("ms.done_flag", done, 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      gap_pat = 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 9) == 0), W'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0), gap_pat[0]);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b0;
        #1 model_reset();
        check_model("rnd.rst");
        @(negedge clk); rst = 1'b1;
      end else begin
        step("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
